mem_crc_reader: RTL
===================

// Module: mem_crc_reader
// PURPOSE
// - Read side of the CRC-protected memory path. On a start request, reads one
//   word from a synchronous memory. The word is {stored_crc, data}.
// - Recomputes the CRC over the data bits serially, MSB first.
// - Compares the result with the stored CRC and returns the data plus a CRC
//   error flag with a one-cycle done pulse.
// - Sits between the memory array and the consumer, opposite the CRC-generating
//   write path.
// PARAMETERS
// - DATA_W    8      data bits per memory word
// - CRC_W     8      CRC bits per memory word; stored in the upper CRC_W bits
// - ADDR_W    4      memory address width
// - POLY      8'h07  CRC generator polynomial, implicit x^CRC_W term
// - CRC_INIT  8'h00  CRC register seed at the start of each word
// PORTS
// - clk        input   1               rising-edge clock
// - reset      input   1               reset, asynchronous and active-low (0 = reset)
// - start      input   1               read request; sampled only in IDLE
// - addr       input   ADDR_W          word address; captured with start
// - mem_re     output  1               memory read enable; one-cycle pulse
// - mem_addr   output  ADDR_W          memory address; held from capture to done
// - mem_rdata  input   DATA_W+CRC_W    memory read data; valid 1 cycle after mem_re
// - busy       output  1               high from start acceptance until done
// - done       output  1               one-cycle pulse; result valid
// - data_out   output  DATA_W          data field of the word read
// - crc_err    output  1               1 = recomputed CRC != stored CRC
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; mem_re, busy, done and crc_err = 0;
//   mem_addr and data_out = 0; CRC register = CRC_INIT; bit counter = 0.
//   Applies immediately, including mid-operation; no done is produced for an
//   aborted read.
// - FSM states and transitions:
//   IDLE: on start=1, capture addr, go to READ.
//   READ: mem_re=1 for one cycle, go to WAIT.
//   WAIT: latch mem_rdata into the word register, crc=CRC_INIT, cnt=0, go to SHIFT.
//   SHIFT: DATA_W cycles, one data bit per cycle, MSB first.
//   DONE: one cycle, done=1, go to IDLE.
// - CRC step: fb = crc[CRC_W-1] ^ bit; crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
// - On the last SHIFT cycle, register the results: data_out = data field,
//   crc_err = (next crc != stored field).
// - Latency: the start-sampling edge is edge 1. done is high in the cycle after
//   edge DATA_W+3 (edge 11 at defaults).
// - busy=1 in READ, WAIT, SHIFT and DONE. start is ignored while busy; it is not
//   queued.
// - A new start may be accepted in the cycle after done.
// - data_out and crc_err hold their values until the next done and are not
//   cleared at start.
// - mem_rdata is sampled only in WAIT; it is don't-care at all other times.
// - Counter width: $clog2(DATA_W)+1 bits; it never wraps within a word.
// STRUCTURE
// - Shared package/header: the FSM state encodings, default POLY/CRC_INIT, and
//   the CRC-8 constants shared with the write-side generator.
// - One sub-module, crc_serial_step: a combinational single-bit CRC update
//   (crc_in, bit, POLY -> crc_out). The write path reuses it.
// TESTING
// - Word 0x07_01 (stored crc 0x07, data 0x01) -> done at edge 11, data_out=0x01,
//   crc_err=0.
// - Word 0xF3_FF -> data_out=0xFF, crc_err=0.
// - Word 0xF2_FF (one stored-CRC bit flipped) -> data_out=0xFF, crc_err=1.
// - Word 0x00_00 -> crc_err=0. Pulse start again on the cycle after done -> a
//   second done exactly 11 edges after the new start.
// - start held high, or re-pulsed mid-SHIFT -> exactly one mem_re and one done
//   per accepted request.
// - reset=0 during SHIFT -> all outputs 0 immediately, no done. After release,
//   a new start completes normally.

Source files
------------

// File: rtl/mem_crc_reader_pkg.sv
// Shared definitions for the CRC-protected memory path: default geometry,
// CRC-8 constants used by both the read and write sides, and reader FSM states.
package mem_crc_reader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CRC_W  = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_crc_reader_if.sv
// Request/memory/result bundle of the CRC reader. The reader takes the slave
// view; the consumer plus memory side takes the master view.
interface mem_crc_reader_if
    import mem_crc_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CRC_W  = DEF_CRC_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                    start;
    logic [ADDR_W-1:0]       addr;
    logic                    mem_re;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W+CRC_W-1:0] mem_rdata;
    logic                    busy;
    logic                    done;
    logic [DATA_W-1:0]       data_out;
    logic                    crc_err;

    modport slave (
        input  start, addr, mem_rdata,
        output mem_re, mem_addr, busy, done, data_out, crc_err
    );

    modport master (
        output start, addr, mem_rdata,
        input  mem_re, mem_addr, busy, done, data_out, crc_err
    );

endinterface

// File: rtl/crc_serial_step.sv
// Single-bit serial CRC update, MSB-first; shared with the write-side generator.
module crc_serial_step #(
    parameter int CRC_W = 8
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic             data_bit,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crc_out
);
    logic fb;

    assign fb      = crc_in[CRC_W-1] ^ data_bit;
    assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule

// File: rtl/mem_crc_reader.sv
// Reads one {stored_crc, data} word from synchronous memory, recomputes the CRC
// bit-serially over the data and reports the data with a CRC mismatch flag.
module mem_crc_reader
    import mem_crc_reader_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               CRC_W    = DEF_CRC_W,
    parameter int               ADDR_W   = DEF_ADDR_W,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(CRC8_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC8_INIT)
) (
    input  logic           clk,
    input  logic           reset,
    mem_crc_reader_if.slave bus
);
    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int WORD_W = DATA_W + CRC_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CRC_W-1:0]  stored_q, stored_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [CRC_W-1:0]  crc_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              crc_err_q, crc_err_d;

    // The data MSB is always presented at the top of the shift register.
    crc_serial_step #(.CRC_W(CRC_W)) u_step (
        .crc_in  (crc_q),
        .data_bit(shift_q[DATA_W-1]),
        .poly    (POLY),
        .crc_out (crc_step)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            stored_q   <= '0;
            crc_q      <= CRC_INIT;
            cnt_q      <= '0;
            data_out_q <= '0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            stored_q   <= stored_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            crc_err_q  <= crc_err_d;
        end
    end

    // NOTE: every variable is defaulted to its held value first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        shift_d    = shift_q;
        stored_d   = stored_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        crc_err_d  = crc_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.addr;
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                data_d   = bus.mem_rdata[DATA_W-1:0];
                shift_d  = bus.mem_rdata[DATA_W-1:0];
                stored_d = bus.mem_rdata[WORD_W-1:DATA_W];
                crc_d    = CRC_INIT;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                crc_d   = crc_step;
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    data_out_d = data_q;
                    crc_err_d  = (crc_step != stored_q);
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_re   = (state_q == ST_READ);
    assign bus.mem_addr = addr_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.data_out = data_out_q;
    assign bus.crc_err  = crc_err_q;

endmodule
